// File: rtl/scope_trig_status_pio.sv
// Avalon-MM status input PIO: synchronizes in_port, captures selected edges per bit
// and raises a level irq for captured edges that are unmasked.
module scope_trig_status_pio #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned EDGE_TYPE   = 0,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int unsigned GUARD_MAX = SYNC_STAGES + 1;
    localparam int unsigned GUARD_W   = $clog2(GUARD_MAX + 1);

    localparam logic [1:0] ADDR_DATA = 2'd0;
    localparam logic [1:0] ADDR_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE = 2'd3;

    if (EDGE_TYPE > 2) begin : g_bad_edge_type
        $error("EDGE_TYPE must be 0 (rising), 1 (falling) or 2 (any)");
    end
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
        $error("WIDTH must be in 1..32");
    end
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
        $error("SYNC_STAGES must be in 2..4");
    end

    logic [WIDTH-1:0]   sync_q [SYNC_STAGES];
    logic [WIDTH-1:0]   sync_in;
    logic [WIDTH-1:0]   prev_in;
    logic [WIDTH-1:0]   irq_mask;
    logic [WIDTH-1:0]   edge_cap;
    logic [WIDTH-1:0]   edge_cap_nxt;
    logic [WIDTH-1:0]   rise;
    logic [WIDTH-1:0]   fall;
    logic [WIDTH-1:0]   edge_det;
    logic [WIDTH-1:0]   clr_bits;
    logic [GUARD_W-1:0] guard_cnt;
    logic               guard_done;
    logic               wr_en;
    logic [31:0]        rd_nxt;
    logic               unused_wdata;

    assign sync_in      = sync_q[SYNC_STAGES-1];
    assign unused_wdata = ^writedata;

    // Synchronizer chain plus one history flop for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= '0;
            end
            prev_in <= '0;
        end else begin
            sync_q[0] <= in_port;
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_in <= sync_in;
        end
    end

    // Guard keeps inputs already high at reset from looking like a rising edge
    always_ff @(posedge clk) begin
        if (reset) begin
            guard_cnt <= '0;
        end else if (!guard_done) begin
            guard_cnt <= guard_cnt + GUARD_W'(1);
        end
    end

    assign rise = sync_in & ~prev_in;
    assign fall = ~sync_in & prev_in;

    if (EDGE_TYPE == 0) begin : g_rise
        assign edge_det = rise;
    end else if (EDGE_TYPE == 1) begin : g_fall
        assign edge_det = fall;
    end else begin : g_any
        assign edge_det = rise | fall;
    end

    always_comb begin
        wr_en        = 1'b0;
        guard_done   = 1'b0;
        clr_bits     = '0;
        edge_cap_nxt = edge_cap;
        rd_nxt       = '0;

        wr_en      = chipselect & ~write_n;
        guard_done = (guard_cnt == GUARD_W'(GUARD_MAX));

        if (wr_en && (address == ADDR_EDGE)) begin
            clr_bits = writedata[WIDTH-1:0];
        end
        // A new edge overrides a same-cycle write-1-to-clear
        edge_cap_nxt = (edge_cap & ~clr_bits) | (guard_done ? edge_det : '0);

        case (address)
            ADDR_DATA: rd_nxt = 32'(sync_in);
            ADDR_MASK: rd_nxt = 32'(irq_mask);
            ADDR_EDGE: rd_nxt = 32'(edge_cap);
            default:   rd_nxt = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask <= '0;
            edge_cap <= '0;
            readdata <= '0;
        end else begin
            if (wr_en && (address == ADDR_MASK)) begin
                irq_mask <= writedata[WIDTH-1:0];
            end
            edge_cap <= edge_cap_nxt;
            readdata <= rd_nxt;
        end
    end

    assign irq = |(edge_cap & irq_mask);

endmodule
